// File: rtl/pcie_rd_tag_sched.sv
`default_nettype none
// ============================================================================
// Module   : pcie_rd_tag_sched
// Purpose  : PCIe read-request scheduler. Arbitrates DMA read requests from
//            REQ_NUM requesters round-robin, allocates the lowest free PCIe
//            tag, issues one read command per tag through a 1-deep output
//            slot, and snoops the RC completion stream to route each
//            completion back to its requester and free the tag when the
//            request completes.
// Ports    : pcie_clk / pcie_rst_n   clock, async active-low reset
//            req_valid/addr/len      per-requester read requests
//            req_ready               per-requester accept (comb, one-hot/0)
//            rq_cmd_*                read command to the RQ assembler
//            cpl_valid/sop/tag/req_done   RC completion beat snoop
//            cpl_route_*             registered routing result
//            tag_free_cnt            number of free tags
//            err_sticky              [0] cpl on free tag, [1] tag out of range
//            odbg_info               packed debug word
// Revision : 1.0  initial release
// ============================================================================
module pcie_rd_tag_sched #(
    parameter int REQ_NUM = 4,
    parameter int TAG_NUM = 32,
    parameter int TAG_W   = 5,
    parameter int ID_W    = 2
) (
    input  logic                   pcie_clk,
    input  logic                   pcie_rst_n,
    input  logic [REQ_NUM-1:0]     req_valid,
    input  logic [REQ_NUM*64-1:0]  req_addr,
    input  logic [REQ_NUM*11-1:0]  req_len,
    output logic [REQ_NUM-1:0]     req_ready,
    output logic                   rq_cmd_valid,
    output logic [63:0]            rq_cmd_addr,
    output logic [10:0]            rq_cmd_len,
    output logic [7:0]             rq_cmd_tag,
    input  logic                   rq_cmd_ready,
    input  logic                   cpl_valid,
    input  logic                   cpl_sop,
    input  logic [7:0]             cpl_tag,
    input  logic                   cpl_req_done,
    output logic                   cpl_route_valid,
    output logic [ID_W-1:0]        cpl_route_id,
    output logic                   cpl_route_last,
    output logic [TAG_W:0]         tag_free_cnt,
    output logic [1:0]             err_sticky,
    output logic [15:0]            odbg_info
);

    localparam logic [TAG_W:0] c_tag_num = (TAG_W+1)'(TAG_NUM);
    localparam logic [8:0]     c_tag_lim = 9'(TAG_NUM);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [TAG_NUM-1:0] r_tag_busy;
    logic [ID_W-1:0]    r_owner [TAG_NUM];
    logic [ID_W-1:0]    r_ptr;
    logic               r_cmd_valid;
    logic [63:0]        r_cmd_addr;
    logic [10:0]        r_cmd_len;
    logic [TAG_W-1:0]   r_cmd_tag;
    logic [TAG_W:0]     r_free_cnt;
    logic [1:0]         r_err;
    logic               r_route_valid;
    logic [ID_W-1:0]    r_route_id;
    logic               r_route_last;

    // ------------------------------------------------------------------------
    // Grant path
    // ------------------------------------------------------------------------
    logic               w_slot_load;
    logic               w_any_free;
    logic               w_found;
    logic [ID_W-1:0]    w_gnt_id;
    logic [TAG_W-1:0]   w_alloc_tag;
    logic               w_grant;

    assign w_slot_load = ~r_cmd_valid | rq_cmd_ready;
    assign w_any_free  = |(~r_tag_busy);

    // First valid requester at or after the pointer, wrapping upward.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_gnt_id = '0;
        idx      = 0;
        for (int k = 0; k < REQ_NUM; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            if (!w_found && req_valid[idx]) begin
                w_found  = 1'b1;
                w_gnt_id = ID_W'(idx);
            end
        end
    end

    // Lowest-index free tag: scan downward so the last hit wins.
    always_comb begin
        w_alloc_tag = '0;
        for (int t = TAG_NUM - 1; t >= 0; t--) begin
            if (!r_tag_busy[t]) w_alloc_tag = TAG_W'(t);
        end
    end

    // Gated by reset so req_ready stays low while the block is held in reset.
    assign w_grant = pcie_rst_n & w_slot_load & w_any_free & w_found;

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_gnt_id] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Completion snoop
    // ------------------------------------------------------------------------
    logic               w_cpl_hit;
    logic               w_tag_oob;
    logic [TAG_W-1:0]   w_cpl_idx;
    logic               w_cpl_busy;
    logic               w_free;

    assign w_cpl_hit  = cpl_valid & cpl_sop;
    assign w_tag_oob  = {1'b0, cpl_tag} >= c_tag_lim;
    assign w_cpl_idx  = cpl_tag[TAG_W-1:0];
    assign w_cpl_busy = r_tag_busy[w_cpl_idx];
    // Freed tag is busy at the start of the cycle, the allocated tag is free,
    // so a simultaneous alloc and free never touch the same entry.
    assign w_free     = w_cpl_hit & ~w_tag_oob & w_cpl_busy & cpl_req_done;

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            r_tag_busy    <= '0;
            for (int t = 0; t < TAG_NUM; t++) r_owner[t] <= '0;
            r_ptr         <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_len     <= '0;
            r_cmd_tag     <= '0;
            r_free_cnt    <= c_tag_num;
            r_err         <= '0;
            r_route_valid <= 1'b0;
            r_route_id    <= '0;
            r_route_last  <= 1'b0;
        end else begin
            // Output skid slot
            if (w_grant) begin
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= req_addr[w_gnt_id*64 +: 64];
                r_cmd_len   <= req_len[w_gnt_id*11 +: 11];
                r_cmd_tag   <= w_alloc_tag;
                r_owner[w_alloc_tag] <= w_gnt_id;
                r_ptr       <= (int'(w_gnt_id) == REQ_NUM - 1) ? '0 : w_gnt_id + 1'b1;
            end else if (rq_cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end

            // Tag pool
            if (w_grant) r_tag_busy[w_alloc_tag] <= 1'b1;
            if (w_free)  r_tag_busy[w_cpl_idx]   <= 1'b0;
            r_free_cnt <= r_free_cnt + (TAG_W+1)'(w_free) - (TAG_W+1)'(w_grant);

            // Routing result; out-of-range tags are not routed at all
            r_route_valid <= w_cpl_hit & ~w_tag_oob;
            if (w_cpl_hit & ~w_tag_oob) begin
                r_route_id   <= r_owner[w_cpl_idx];
                r_route_last <= cpl_req_done;
            end else begin
                r_route_last <= 1'b0;
            end

            // Sticky errors
            if (w_cpl_hit) begin
                if (w_tag_oob)        r_err[1] <= 1'b1;
                else if (!w_cpl_busy) r_err[0] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rq_cmd_valid    = r_cmd_valid;
    assign rq_cmd_addr     = r_cmd_addr;
    assign rq_cmd_len      = r_cmd_len;
    assign rq_cmd_tag      = 8'(r_cmd_tag);
    assign cpl_route_valid = r_route_valid;
    assign cpl_route_id    = r_route_id;
    assign cpl_route_last  = r_route_last;
    assign tag_free_cnt    = r_free_cnt;
    assign err_sticky      = r_err;
    assign odbg_info       = {r_err, r_cmd_valid, rq_cmd_ready, 3'b000, 9'(r_free_cnt)};

endmodule
`default_nettype wire

// File: tb/tb_pcie_rd_tag_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_rd_tag_sched
// Purpose  : Directed self-checking bench for pcie_rd_tag_sched.
// Revision : 1.0  initial release
// ============================================================================
module tb_pcie_rd_tag_sched;

    localparam int REQ_NUM = 4;
    localparam int TAG_NUM = 32;
    localparam int TAG_W   = 5;
    localparam int ID_W    = 2;

    logic                   pcie_clk;
    logic                   pcie_rst_n;
    logic [REQ_NUM-1:0]     req_valid;
    logic [REQ_NUM*64-1:0]  req_addr;
    logic [REQ_NUM*11-1:0]  req_len;
    logic [REQ_NUM-1:0]     req_ready;
    logic                   rq_cmd_valid;
    logic [63:0]            rq_cmd_addr;
    logic [10:0]            rq_cmd_len;
    logic [7:0]             rq_cmd_tag;
    logic                   rq_cmd_ready;
    logic                   cpl_valid;
    logic                   cpl_sop;
    logic [7:0]             cpl_tag;
    logic                   cpl_req_done;
    logic                   cpl_route_valid;
    logic [ID_W-1:0]        cpl_route_id;
    logic                   cpl_route_last;
    logic [TAG_W:0]         tag_free_cnt;
    logic [1:0]             err_sticky;
    logic [15:0]            odbg_info;

    int n_checks = 0;
    int n_fail   = 0;

    pcie_rd_tag_sched #(
        .REQ_NUM(REQ_NUM), .TAG_NUM(TAG_NUM), .TAG_W(TAG_W), .ID_W(ID_W)
    ) dut (
        .pcie_clk        (pcie_clk),
        .pcie_rst_n      (pcie_rst_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_ready       (req_ready),
        .rq_cmd_valid    (rq_cmd_valid),
        .rq_cmd_addr     (rq_cmd_addr),
        .rq_cmd_len      (rq_cmd_len),
        .rq_cmd_tag      (rq_cmd_tag),
        .rq_cmd_ready    (rq_cmd_ready),
        .cpl_valid       (cpl_valid),
        .cpl_sop         (cpl_sop),
        .cpl_tag         (cpl_tag),
        .cpl_req_done    (cpl_req_done),
        .cpl_route_valid (cpl_route_valid),
        .cpl_route_id    (cpl_route_id),
        .cpl_route_last  (cpl_route_last),
        .tag_free_cnt    (tag_free_cnt),
        .err_sticky      (err_sticky),
        .odbg_info       (odbg_info)
    );

    initial pcie_clk = 1'b0;
    always #5 pcie_clk = ~pcie_clk;

    // Requester i: address (i+1)*0x1000, length i+1 DW unless overridden.
    task automatic set_addrs();
        for (int i = 0; i < REQ_NUM; i++) begin
            req_addr[i*64 +: 64] = 64'(i + 1) << 12;
            req_len[i*11 +: 11]  = 11'(i + 1);
        end
    endtask

    // Holds reset for two cycles; returns at a falling edge with reset released.
    task automatic do_reset();
        pcie_rst_n   = 1'b0;
        req_valid    = '0;
        rq_cmd_ready = 1'b0;
        cpl_valid    = 1'b0;
        cpl_sop      = 1'b0;
        cpl_tag      = '0;
        cpl_req_done = 1'b0;
        set_addrs();
        repeat (2) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        pcie_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rq_cmd_valid, rq_cmd_addr, rq_cmd_len, rq_cmd_tag,
             cpl_route_valid, cpl_route_id, cpl_route_last, err_sticky} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, need all zero");
        end
        n_checks++;
        if (tag_free_cnt !== 6'd32) begin
            n_fail++; $display("FAIL reset_free_cnt: got %0d need 32", tag_free_cnt);
        end
        n_checks++;
        if (odbg_info !== 16'h0020) begin
            n_fail++; $display("FAIL reset_odbg: got %h need 0020", odbg_info);
        end
        @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
    endtask

    task automatic test_first_grant();
        do_reset();
        req_addr[63:0] = 64'h1000;
        req_len[10:0]  = 11'd16;
        req_valid      = 4'b0001;
        rq_cmd_ready   = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL first_ready: got %b need 0001", req_ready);
        end
        @(negedge pcie_clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (rq_cmd_valid !== 1'b1 || rq_cmd_addr !== 64'h1000 || rq_cmd_len !== 11'd16 || rq_cmd_tag !== 8'd0) begin
            n_fail++; $display("FAIL first_cmd: got v=%b a=%h l=%0d t=%0d need v=1 a=1000 l=16 t=0",
                               rq_cmd_valid, rq_cmd_addr, rq_cmd_len, rq_cmd_tag);
        end
        n_checks++;
        if (tag_free_cnt !== 6'd31) begin
            n_fail++; $display("FAIL first_free_cnt: got %0d need 31", tag_free_cnt);
        end
        @(negedge pcie_clk);
        #1;
        n_checks++;
        if (rq_cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL first_cmd_drop: got %b need 0", rq_cmd_valid);
        end
    endtask

    // Leaves the pool exhausted with all requesters still valid and pointer 0.
    task automatic test_round_robin();
        int exp_cnt;
        int exp_ptr;
        int prev_g;
        int prev_tag;
        bit prev_grant;
        int gcount [REQ_NUM];
        logic [REQ_NUM-1:0] exp_rdy;
        do_reset();
        rq_cmd_ready = 1'b1;
        req_valid    = 4'hF;
        exp_cnt = TAG_NUM; exp_ptr = 0; prev_g = 0; prev_tag = 0; prev_grant = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) gcount[i] = 0;
        for (int it = 0; it < 36; it++) begin
            #1;
            exp_rdy = (exp_cnt > 0) ? REQ_NUM'(1 << exp_ptr) : '0;
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b need %b", it, req_ready, exp_rdy);
            end
            n_checks++;
            if (rq_cmd_valid !== prev_grant) begin
                n_fail++; $display("FAIL rr_cmd_valid[%0d]: got %b need %b", it, rq_cmd_valid, prev_grant);
            end
            if (prev_grant) begin
                n_checks++;
                if (rq_cmd_tag !== 8'(prev_tag) || rq_cmd_addr !== (64'(prev_g + 1) << 12)) begin
                    n_fail++; $display("FAIL rr_cmd_fields[%0d]: got t=%0d a=%h need t=%0d a=%h",
                                       it, rq_cmd_tag, rq_cmd_addr, prev_tag, 64'(prev_g + 1) << 12);
                end
            end
            n_checks++;
            if (tag_free_cnt !== 6'(exp_cnt)) begin
                n_fail++; $display("FAIL rr_free_cnt[%0d]: got %0d need %0d", it, tag_free_cnt, exp_cnt);
            end
            if (exp_cnt > 0) begin
                prev_grant = 1'b1;
                prev_g     = exp_ptr;
                prev_tag   = TAG_NUM - exp_cnt;
                gcount[exp_ptr]++;
                exp_cnt--;
                exp_ptr = (exp_ptr + 1) % REQ_NUM;
            end else begin
                prev_grant = 1'b0;
            end
            @(negedge pcie_clk);
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            n_checks++;
            if (gcount[i] != 8) begin
                n_fail++; $display("FAIL rr_share[%0d]: got %0d need 8", i, gcount[i]);
            end
        end
    endtask

    // Continues from the exhausted pool; tag 5 belongs to requester 1.
    task automatic test_pool_refill();
        cpl_valid = 1'b1; cpl_sop = 1'b1; cpl_tag = 8'd5; cpl_req_done = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL refill_same_cycle: got %b need 0000", req_ready);
        end
        @(negedge pcie_clk);
        cpl_valid = 1'b0; cpl_sop = 1'b0; cpl_req_done = 1'b0;
        #1;
        n_checks++;
        if (cpl_route_valid !== 1'b1 || cpl_route_id !== 2'd1 || cpl_route_last !== 1'b1) begin
            n_fail++; $display("FAIL refill_route: got v=%b id=%0d last=%b need v=1 id=1 last=1",
                               cpl_route_valid, cpl_route_id, cpl_route_last);
        end
        n_checks++;
        if (tag_free_cnt !== 6'd1) begin
            n_fail++; $display("FAIL refill_free_cnt: got %0d need 1", tag_free_cnt);
        end
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL refill_ready: got %b need 0001", req_ready);
        end
        @(negedge pcie_clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (rq_cmd_valid !== 1'b1 || rq_cmd_tag !== 8'd5 || rq_cmd_addr !== 64'h1000) begin
            n_fail++; $display("FAIL refill_cmd: got v=%b t=%0d a=%h need v=1 t=5 a=1000",
                               rq_cmd_valid, rq_cmd_tag, rq_cmd_addr);
        end
        n_checks++;
        if (tag_free_cnt !== 6'd0 || cpl_route_valid !== 1'b0) begin
            n_fail++; $display("FAIL refill_after: got cnt=%0d rv=%b need cnt=0 rv=0",
                               tag_free_cnt, cpl_route_valid);
        end
    endtask

    task automatic test_partial_cpl();
        do_reset();
        rq_cmd_ready = 1'b1;
        req_valid    = 4'b0100;
        repeat (4) @(negedge pcie_clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (tag_free_cnt !== 6'd28 || rq_cmd_tag !== 8'd3) begin
            n_fail++; $display("FAIL part_alloc: got cnt=%0d t=%0d need cnt=28 t=3", tag_free_cnt, rq_cmd_tag);
        end
        cpl_valid = 1'b1; cpl_sop = 1'b1; cpl_tag = 8'd3; cpl_req_done = 1'b0;
        @(negedge pcie_clk);
        // non-sop beat with req_done set must be ignored
        cpl_sop = 1'b0; cpl_req_done = 1'b1;
        #1;
        n_checks++;
        if (cpl_route_valid !== 1'b1 || cpl_route_id !== 2'd2 || cpl_route_last !== 1'b0 || tag_free_cnt !== 6'd28) begin
            n_fail++; $display("FAIL part_first: got v=%b id=%0d last=%b cnt=%0d need v=1 id=2 last=0 cnt=28",
                               cpl_route_valid, cpl_route_id, cpl_route_last, tag_free_cnt);
        end
        @(negedge pcie_clk);
        cpl_sop = 1'b1;
        #1;
        n_checks++;
        if (cpl_route_valid !== 1'b0 || tag_free_cnt !== 6'd28) begin
            n_fail++; $display("FAIL part_nonsop: got v=%b cnt=%0d need v=0 cnt=28", cpl_route_valid, tag_free_cnt);
        end
        @(negedge pcie_clk);
        cpl_valid = 1'b0; cpl_sop = 1'b0; cpl_req_done = 1'b0;
        #1;
        n_checks++;
        if (cpl_route_valid !== 1'b1 || cpl_route_id !== 2'd2 || cpl_route_last !== 1'b1 || tag_free_cnt !== 6'd29) begin
            n_fail++; $display("FAIL part_second: got v=%b id=%0d last=%b cnt=%0d need v=1 id=2 last=1 cnt=29",
                               cpl_route_valid, cpl_route_id, cpl_route_last, tag_free_cnt);
        end
        @(negedge pcie_clk);
        #1;
        n_checks++;
        if (cpl_route_valid !== 1'b0) begin
            n_fail++; $display("FAIL part_idle: got v=%b need 0", cpl_route_valid);
        end
    endtask

    task automatic test_stall();
        int grants;
        do_reset();
        rq_cmd_ready = 1'b0;
        req_valid    = 4'b0011;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL stall_first: got %b need 0001", req_ready);
        end
        grants = 1;
        @(negedge pcie_clk);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (rq_cmd_valid !== 1'b1 || rq_cmd_addr !== 64'h1000 || rq_cmd_tag !== 8'd0 || rq_cmd_len !== 11'd1) begin
                n_fail++; $display("FAIL stall_hold[%0d]: got v=%b a=%h t=%0d l=%0d need v=1 a=1000 t=0 l=1",
                                   c, rq_cmd_valid, rq_cmd_addr, rq_cmd_tag, rq_cmd_len);
            end
            if (req_ready !== '0) grants++;
            @(negedge pcie_clk);
        end
        n_checks++;
        if (grants != 1) begin
            n_fail++; $display("FAIL stall_grants: got %0d need 1", grants);
        end
        rq_cmd_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL stall_release: got %b need 0010", req_ready);
        end
        @(negedge pcie_clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (rq_cmd_valid !== 1'b1 || rq_cmd_tag !== 8'd1 || rq_cmd_addr !== 64'h2000 || tag_free_cnt !== 6'd30) begin
            n_fail++; $display("FAIL stall_next: got v=%b t=%0d a=%h cnt=%0d need v=1 t=1 a=2000 cnt=30",
                               rq_cmd_valid, rq_cmd_tag, rq_cmd_addr, tag_free_cnt);
        end
    endtask

    task automatic test_errors();
        do_reset();
        rq_cmd_ready = 1'b1;
        cpl_valid = 1'b1; cpl_sop = 1'b1; cpl_tag = 8'd9; cpl_req_done = 1'b1;
        @(negedge pcie_clk);
        cpl_valid = 1'b0; cpl_sop = 1'b0; cpl_req_done = 1'b0;
        #1;
        n_checks++;
        if (err_sticky !== 2'b01 || cpl_route_valid !== 1'b1 || cpl_route_id !== 2'd0 || tag_free_cnt !== 6'd32) begin
            n_fail++; $display("FAIL err_free_tag: got err=%b v=%b id=%0d cnt=%0d need err=01 v=1 id=0 cnt=32",
                               err_sticky, cpl_route_valid, cpl_route_id, tag_free_cnt);
        end
        cpl_valid = 1'b1; cpl_sop = 1'b1; cpl_tag = 8'd40; cpl_req_done = 1'b1;
        @(negedge pcie_clk);
        cpl_valid = 1'b0; cpl_sop = 1'b0; cpl_req_done = 1'b0;
        #1;
        n_checks++;
        if (err_sticky !== 2'b11 || cpl_route_valid !== 1'b0 || tag_free_cnt !== 6'd32) begin
            n_fail++; $display("FAIL err_oob: got err=%b v=%b cnt=%0d need err=11 v=0 cnt=32",
                               err_sticky, cpl_route_valid, tag_free_cnt);
        end
        n_checks++;
        if (odbg_info !== 16'hD020) begin
            n_fail++; $display("FAIL err_odbg: got %h need d020", odbg_info);
        end
    endtask

    // Continues with err_sticky = 11 from the previous task.
    task automatic test_mid_reset();
        req_valid = 4'hF;
        repeat (3) @(negedge pcie_clk);
        cpl_valid = 1'b1; cpl_sop = 1'b1; cpl_tag = 8'd0; cpl_req_done = 1'b1;
        pcie_rst_n = 1'b0;
        #1;
        n_checks++;
        if (rq_cmd_valid !== 1'b0 || req_ready !== '0 || cpl_route_valid !== 1'b0 || err_sticky !== 2'b00) begin
            n_fail++; $display("FAIL midrst_outputs: got cv=%b rdy=%b rv=%b err=%b need all 0",
                               rq_cmd_valid, req_ready, cpl_route_valid, err_sticky);
        end
        n_checks++;
        if (tag_free_cnt !== 6'd32 || odbg_info !== 16'h1020) begin
            n_fail++; $display("FAIL midrst_cnt: got cnt=%0d odbg=%h need cnt=32 odbg=1020", tag_free_cnt, odbg_info);
        end
        @(negedge pcie_clk);
        cpl_valid = 1'b0; cpl_sop = 1'b0; cpl_req_done = 1'b0;
        req_valid = '0;
        pcie_rst_n = 1'b1;
        @(negedge pcie_clk);
        #1;
        n_checks++;
        if (cpl_route_valid !== 1'b0 || rq_cmd_valid !== 1'b0 || tag_free_cnt !== 6'd32) begin
            n_fail++; $display("FAIL midrst_after: got rv=%b cv=%b cnt=%0d need rv=0 cv=0 cnt=32",
                               cpl_route_valid, rq_cmd_valid, tag_free_cnt);
        end
    endtask

    initial begin
        req_addr = '0;
        req_len  = '0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_pool_refill();
        test_partial_cpl();
        test_stall();
        test_errors();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, need finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
